msrv32_alu_md: RTL and testbench

- Parametrised, multicycle successor to the RV32 integer ALU. Executes all RV32I register/immediate ALU ops plus the RV32M multiply/divide ops (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
- Sits in the execute stage behind a valid/ready handshake, so the pipeline can stall on iterative multiply/divide.
- Multiply is radix-2 shift-add; divide is radix-2 restoring. One bit is processed per clock.

---
 rtl/msrv32_alu_md.sv | 193 +++++++++++++++++++
 tb/tb_msrv32_alu_md.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/msrv32_alu_md.sv
// RV32I ALU plus RV32M multiply/divide behind a valid/ready handshake; one bit per clock for mul/div.
// Build option MSRV32_MD_FAST_MUL_EN swaps the shift-add multiplier for a single-cycle multiplier.
module msrv32_alu_md #(
  parameter int WIDTH = 32
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             flush_in,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic [WIDTH-1:0] op_1_in,
  input  logic [WIDTH-1:0] op_2_in,
  input  logic [4:0]       opcode_in,
  output logic [WIDTH-1:0] result_out,
  output logic             valid_out,
  input  logic             ready_in
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MUL  = 3'd1;
  localparam logic [2:0] S_DIV  = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  logic [2:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2:0]         f3_q, f3_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   result_q, result_d;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x, input logic n);
    return n ? ('0 - x) : x;
  endfunction

  logic [2:0]              f3;
  logic                    sgn1, sgn2, sa, sb;
  logic [WIDTH-1:0]        abs1, abs2, base_res;
  logic [SHW-1:0]          shamt;
  logic signed [WIDTH-1:0] sra_res;

  assign f3      = opcode_in[2:0];
  assign shamt   = op_2_in[SHW-1:0];
  // Divide ops are signed when funct3[0]=0; MULH/MULHSU treat op_1 as signed, only MULH op_2.
  assign sgn1    = f3[2] ? ~f3[0] : (f3[1] ^ f3[0]);
  assign sgn2    = f3[2] ? ~f3[0] : (f3 == 3'b001);
  assign sa      = sgn1 & op_1_in[WIDTH-1];
  assign sb      = sgn2 & op_2_in[WIDTH-1];
  assign abs1    = cond_neg(op_1_in, sa);
  assign abs2    = cond_neg(op_2_in, sb);
  assign sra_res = $signed(op_1_in) >>> shamt;

  always_comb begin
    base_res = '0;
    case (f3)
      3'b000:  base_res = opcode_in[3] ? (op_1_in - op_2_in) : (op_1_in + op_2_in);
      3'b001:  base_res = op_1_in << shamt;
      3'b010:  base_res = {{(WIDTH-1){1'b0}}, $signed(op_1_in) < $signed(op_2_in)};
      3'b011:  base_res = {{(WIDTH-1){1'b0}}, op_1_in < op_2_in};
      3'b100:  base_res = op_1_in ^ op_2_in;
      3'b101:  base_res = opcode_in[3] ? sra_res : (op_1_in >> shamt);
      3'b110:  base_res = op_1_in | op_2_in;
      default: base_res = op_1_in & op_2_in;
    endcase
  end

`ifdef MSRV32_MD_FAST_MUL_EN
  logic [2*WIDTH-1:0] x1w, x2w, fast_p;
  assign x1w    = {{WIDTH{sa}}, op_1_in};
  assign x2w    = {{WIDTH{sb}}, op_2_in};
  assign fast_p = x1w * x2w;
`endif

  logic [WIDTH:0]       mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     fix_res;

  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? mcand_q : '0)};
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, mcand_q};
  assign prod_fix  = neg_q ? ('0 - acc_q) : acc_q;

  always_comb begin
    fix_res = '0;
    if (!f3_q[2])
      fix_res = (f3_q[1:0] == 2'b00) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];
    else
      fix_res = cond_neg(f3_q[1] ? acc_q[2*WIDTH-1:WIDTH] : acc_q[WIDTH-1:0], neg_q);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    f3_d     = f3_q;
    neg_d    = neg_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (valid_in) begin
          f3_d = f3;
          if (!opcode_in[4]) begin
            result_d = base_res;
            state_d  = S_DONE;
          end else if (f3[2] && (op_2_in == '0)) begin
            result_d = f3[1] ? op_1_in : ALL_ONES;
            state_d  = S_DONE;
          end else if (f3[2] && !f3[0] && (op_1_in == MOST_NEG) && (op_2_in == ALL_ONES)) begin
            result_d = f3[1] ? '0 : MOST_NEG;
            state_d  = S_DONE;
          end else if (f3[2]) begin
            acc_d   = {{WIDTH{1'b0}}, abs1};
            mcand_d = abs2;
            neg_d   = f3[1] ? sa : (sa ^ sb);
            cnt_d   = CW'(WIDTH);
            state_d = S_DIV;
          end else begin
`ifdef MSRV32_MD_FAST_MUL_EN
            acc_d   = fast_p;
            neg_d   = 1'b0;
            state_d = S_FIX;
`else
            acc_d   = {{WIDTH{1'b0}}, abs2};
            mcand_d = abs1;
            neg_d   = sa ^ sb;
            cnt_d   = CW'(WIDTH);
            state_d = S_MUL;
`endif
          end
        end
      end
      S_MUL: begin
        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_FIX;
      end
      S_DIV: begin
        // Quotient bit is 1 when the trial subtract does not borrow; otherwise keep the shifted remainder.
        if (!div_diff[WIDTH])
          acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        else
          acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        result_d = fix_res;
        cnt_d    = '0;
        state_d  = S_DONE;
      end
      S_DONE: begin
        if (ready_in) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush_in) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      f3_q     <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      f3_q     <= f3_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

  assign ready_out  = (state_q == S_IDLE);
  assign valid_out  = (state_q == S_DONE);
  assign result_out = result_q;

endmodule

// File: tb/tb_msrv32_alu_md.sv
// Self-checking bench for msrv32_alu_md: directed vector table, handshake/abort sequences, random ops vs model.
module tb_msrv32_alu_md;
  localparam int W = 32;
  localparam int LAT_M = W + 1;
`ifdef MSRV32_MD_FAST_MUL_EN
  localparam int LAT_MUL = 1;
`else
  localparam int LAT_MUL = W + 1;
`endif

  localparam logic [4:0] OP_ADD = 5'b00000, OP_SUB = 5'b01000, OP_SLL = 5'b00001;
  localparam logic [4:0] OP_SLT = 5'b00010, OP_SLTU = 5'b00011, OP_XOR = 5'b00100;
  localparam logic [4:0] OP_SRL = 5'b00101, OP_SRA = 5'b01101, OP_OR = 5'b00110, OP_AND = 5'b00111;
  localparam logic [4:0] OP_MUL = 5'b10000, OP_MULH = 5'b10001, OP_MULHSU = 5'b10010, OP_MULHU = 5'b10011;
  localparam logic [4:0] OP_DIV = 5'b10100, OP_DIVU = 5'b10101, OP_REM = 5'b10110, OP_REMU = 5'b10111;

  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, vin = 1'b0, rin = 1'b0;
  logic        rdy_o, vout;
  logic [31:0] a = '0, b = '0, res;
  logic [4:0]  opc = '0;

  msrv32_alu_md #(.WIDTH(W)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .flush_in(flush), .valid_in(vin), .ready_out(rdy_o),
    .op_1_in(a), .op_2_in(b), .opcode_in(opc), .result_out(res), .valid_out(vout), .ready_in(rin)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  // Reference: RV32I/M semantics using 64-bit integer arithmetic.
  function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, ux, uy, p;
    logic [63:0] pv;
    int sh;
    sx = $signed(x); sy = $signed(y); ux = x; uy = y;
    sh = int'(y[4:0]);
    if (!op[4]) begin
      case (op[2:0])
        3'd0: return op[3] ? (x - y) : (x + y);
        3'd1: return x << sh;
        3'd2: return (sx < sy) ? 32'd1 : 32'd0;
        3'd3: return (ux < uy) ? 32'd1 : 32'd0;
        3'd4: return x ^ y;
        3'd5: begin p = sx >>> sh; return op[3] ? p[31:0] : (x >> sh); end
        3'd6: return x | y;
        default: return x & y;
      endcase
    end
    case (op[2:0])
      3'd0: begin pv = sx * sy; return pv[31:0]; end
      3'd1: begin pv = sx * sy; return pv[63:32]; end
      3'd2: begin pv = sx * uy; return pv[63:32]; end
      3'd3: begin pv = ux * uy; return pv[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFFFFFF;
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'h80000000;
        p = sx / sy; return p[31:0];
      end
      3'd5: return (y == 0) ? 32'hFFFFFFFF : x / y;
      3'd6: begin
        if (y == 0) return x;
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'h0;
        p = sx % sy; return p[31:0];
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic int model_lat(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
    if (!op[4]) return 0;
    if (!op[2]) return LAT_MUL;
    if (y == 0) return 0;
    if (!op[0] && x == 32'h80000000 && y == 32'hFFFFFFFF) return 0;
    return LAT_M;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // lat = clock edges after the accept edge until valid_out is seen high.
  task automatic run_op(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] r, output int lat);
    @(negedge clk);
    check("ready_before_accept", {31'b0, rdy_o}, 32'd1);
    opc = op; a = x; b = y; vin = 1'b1;
    @(negedge clk);
    vin = 1'b0; a = $urandom; b = $urandom; opc = 5'($urandom);
    lat = 0;
    while (!vout && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    r = res;
    rin = 1'b1;
    @(negedge clk);
    rin = 1'b0;
    check("release_valid_low", {31'b0, vout}, 32'd0);
    check("release_ready_high", {31'b0, rdy_o}, 32'd1);
  endtask

  typedef struct {
    logic [4:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] exp;
    int          lat;
    string       name;
  } vec_t;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    logic [31:0] r;
    int lat, k, seen;
    logic [4:0] rop;
    logic [31:0] rx, ry;

    tbl.push_back('{OP_SUB,    32'h5,        32'h7,        32'hFFFFFFFE, 0,       "SUB"});
    tbl.push_back('{OP_SRA,    32'h80000000, 32'h4,        32'hF8000000, 0,       "SRA"});
    tbl.push_back('{OP_SLT,    32'hFFFFFFFF, 32'h1,        32'h1,        0,       "SLT"});
    tbl.push_back('{OP_SLTU,   32'hFFFFFFFF, 32'h1,        32'h0,        0,       "SLTU"});
    tbl.push_back('{OP_ADD,    32'hFFFFFFFF, 32'h2,        32'h1,        0,       "ADD_wrap"});
    tbl.push_back('{OP_SLL,    32'h1,        32'h2F,       32'h8000,     0,       "SLL_low5"});
    tbl.push_back('{OP_SRL,    32'h80000000, 32'h4,        32'h08000000, 0,       "SRL"});
    tbl.push_back('{OP_XOR,    32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 0,       "XOR"});
    tbl.push_back('{OP_OR,     32'hF0F0F0F0, 32'h0000FFFF, 32'hF0F0FFFF, 0,       "OR"});
    tbl.push_back('{OP_AND,    32'hF0F0F0F0, 32'h0000FFFF, 32'h0000F0F0, 0,       "AND"});
    tbl.push_back('{OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, LAT_MUL, "MULH"});
    tbl.push_back('{OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, LAT_MUL, "MULHSU"});
    tbl.push_back('{OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, LAT_MUL, "MULHU"});
    tbl.push_back('{OP_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, LAT_MUL, "MUL"});
    tbl.push_back('{OP_DIV,    32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, LAT_M,   "DIV"});
    tbl.push_back('{OP_REM,    32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, LAT_M,   "REM"});
    tbl.push_back('{OP_DIVU,   32'd100,      32'd7,        32'd14,       LAT_M,   "DIVU"});
    tbl.push_back('{OP_REMU,   32'd100,      32'd7,        32'd2,        LAT_M,   "REMU"});
    tbl.push_back('{OP_DIV,    32'h1234,     32'h0,        32'hFFFFFFFF, 0,       "DIV_by0"});
    tbl.push_back('{OP_REM,    32'h1234,     32'h0,        32'h1234,     0,       "REM_by0"});
    tbl.push_back('{OP_DIVU,   32'h1234,     32'h0,        32'hFFFFFFFF, 0,       "DIVU_by0"});
    tbl.push_back('{OP_REMU,   32'h1234,     32'h0,        32'h1234,     0,       "REMU_by0"});
    tbl.push_back('{OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0,       "DIV_ovf"});
    tbl.push_back('{OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h0,        0,       "REM_ovf"});

    // Reset state, asserted from time zero.
    #1;
    check("reset_ready", {31'b0, rdy_o}, 32'd1);
    check("reset_valid", {31'b0, vout}, 32'd0);
    check("reset_result", res, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      run_op(tbl[i].op, tbl[i].x, tbl[i].y, r, lat);
      check(tbl[i].name, r, tbl[i].exp);
      check({tbl[i].name, "_latency"}, 32'(lat), 32'(tbl[i].lat));
    end

    // Backpressure: result held, new requests ignored while DONE.
    @(negedge clk);
    opc = OP_DIVU; a = 32'd100; b = 32'd7; vin = 1'b1;
    @(negedge clk);
    vin = 1'b0;
    k = 0;
    while (!vout && k < 100) begin @(negedge clk); k++; end
    check("bp_latency", 32'(k), 32'(LAT_M));
    for (int c = 0; c < 5; c++) begin
      vin = 1'b1; opc = OP_ADD; a = 32'd1; b = 32'd2;
      @(negedge clk);
      check("bp_result_stable", res, 32'd14);
      check("bp_valid_held", {31'b0, vout}, 32'd1);
      check("bp_ready_low", {31'b0, rdy_o}, 32'd0);
    end
    vin = 1'b0; rin = 1'b1;
    @(negedge clk);
    rin = 1'b0;
    check("bp_release_valid", {31'b0, vout}, 32'd0);
    check("bp_release_ready", {31'b0, rdy_o}, 32'd1);
    @(negedge clk);
    check("bp_no_queued_op", {31'b0, vout}, 32'd0);

    // Flush in the 10th DIV cycle.
    opc = OP_DIV; a = 32'd1000; b = 32'd3; vin = 1'b1;
    @(negedge clk);
    vin = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_ready", {31'b0, rdy_o}, 32'd1);
    check("flush_valid", {31'b0, vout}, 32'd0);
    seen = 0;
    repeat (40) begin @(negedge clk); if (vout) seen++; end
    check("flush_no_result", 32'(seen), 32'd0);

    // Flush coinciding with an accept cancels it.
    opc = OP_ADD; a = 32'd3; b = 32'd4; vin = 1'b1; flush = 1'b1;
    @(negedge clk);
    vin = 1'b0; flush = 1'b0;
    check("flush_accept_ready", {31'b0, rdy_o}, 32'd1);
    check("flush_accept_valid", {31'b0, vout}, 32'd0);
    check("flush_accept_result", res, 32'd14);

    // Asynchronous reset in the middle of a multiply.
    @(negedge clk);
    opc = OP_MULHU; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; vin = 1'b1;
    @(negedge clk);
    vin = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("areset_ready", {31'b0, rdy_o}, 32'd1);
    check("areset_valid", {31'b0, vout}, 32'd0);
    check("areset_result", res, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_op(OP_MUL, 32'd3, 32'hFFFFFFFB, r, lat);
    check("after_reset_mul", r, 32'hFFFFFFF1);
    check("after_reset_mul_latency", 32'(lat), 32'(LAT_MUL));

    // Random operations against the reference model.
    for (int n = 0; n < 300; n++) begin
      rop = 5'($urandom);
      rx = pick();
      ry = pick();
      run_op(rop, rx, ry, r, lat);
      check($sformatf("rnd_result op=%05b a=%08h b=%08h", rop, rx, ry), r, model(rop, rx, ry));
      check($sformatf("rnd_latency op=%05b a=%08h b=%08h", rop, rx, ry), 32'(lat), 32'(model_lat(rop, rx, ry)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
